// File: rtl/kbd_scan_decoder_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code decoder.
package kbd_scan_decoder_pkg;

  typedef logic [8:0] keycode;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    PAUSE
  } state_t;

  // Keyboard housekeeping bytes that never carry a key event in IDLE
  function automatic logic is_housekeeping(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == 8'h00) || (b == 8'hFF);
  endfunction

endpackage

// File: rtl/kbd_scan_decoder_if.sv
// Byte-in / key-event-out bundle between the PS/2 receiver, the decoder
// and the per-key toggle decoders.
interface kbd_scan_decoder_if;
  import kbd_scan_decoder_pkg::*;

  logic [7:0] din;
  logic       dinNew;
  keycode     keyCode;
  logic       make;
  logic       brakee;

  // master: byte source that observes the decoded events
  modport master (output din, dinNew, input keyCode, make, brakee);
  // slave: the decoder itself
  modport slave  (input din, dinNew, output keyCode, make, brakee);

endinterface

// File: rtl/kbd_scan_decoder_prefix_timeout.sv
// Prefix timeout counter: counts while enabled, clears on request and
// flags expiry once TIMEOUT_CYCLES-1 is reached.
module kbd_prefix_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // count up while enabled, saturating at the expiry value
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)                  cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (en && (cnt != LAST)) cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/kbd_scan_decoder.sv
// PS/2 set-2 scan-code decoder: turns the received byte stream into 9-bit
// key codes {extended, scan} with single-cycle make/brakee strobes.
// Optional build macro: KBD_REPEAT_FILTER_EN (drops typematic repeats).
module kbd_scan_decoder
  import kbd_scan_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int PAUSE_SKIP     = 7
) (
  input  logic                clk,
  input  logic                resetN,
  kbd_scan_decoder_if.slave   bus
);

  localparam int PW = (PAUSE_SKIP < 1) ? 1 : $clog2(PAUSE_SKIP + 1);

  state_t        state, state_nxt;
  logic [PW-1:0] pause_cnt;
  logic          expire, tmo_clr, tmo_en;
  logic          hit_make, hit_brk, suppress, emit_make;
  keycode        ev_code;
  keycode        key_code_q;
  logic          make_q, brk_q;

  logic [7:0] din;
  logic       dnew;
  assign din  = bus.din;
  assign dnew = bus.dinNew;

  // prefix timeout runs only while a sequence is in progress
  assign tmo_en  = (state != IDLE);
  assign tmo_clr = dnew || (state_nxt == IDLE);

  kbd_prefix_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk    (clk),
    .resetN (resetN),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (expire)
  );

  // state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  // next-state: a byte arriving on the expiry cycle is processed normally
  always_comb begin
    state_nxt = state;
    if (dnew) begin
      unique case (state)
        IDLE: begin
          if      (din == PS2_EXT)   state_nxt = EXT;
          else if (din == PS2_BRK)   state_nxt = BRK;
          else if (din == PS2_PAUSE) state_nxt = PAUSE;
        end
        EXT: begin
          if      (din == PS2_BRK) state_nxt = EXT_BRK;
          else if (din != PS2_EXT) state_nxt = IDLE;
        end
        BRK, EXT_BRK: begin
          if ((din != PS2_EXT) && (din != PS2_BRK)) state_nxt = IDLE;
        end
        PAUSE: begin
          if (pause_cnt <= PW'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (expire) begin
      state_nxt = IDLE;
    end
  end

  // event decode: which byte completes a make or break, and its code
  always_comb begin
    hit_make = 1'b0;
    hit_brk  = 1'b0;
    ev_code  = '0;
    if (dnew) begin
      unique case (state)
        IDLE: begin
          if ((din != PS2_EXT) && (din != PS2_BRK) && (din != PS2_PAUSE) &&
              !is_housekeeping(din)) begin
            hit_make = 1'b1;
            ev_code  = {1'b0, din};
          end
        end
        EXT: begin
          if ((din != PS2_EXT) && (din != PS2_BRK)) begin
            hit_make = 1'b1;
            ev_code  = {1'b1, din};
          end
        end
        BRK: begin
          if ((din != PS2_EXT) && (din != PS2_BRK)) begin
            hit_brk = 1'b1;
            ev_code = {1'b0, din};
          end
        end
        EXT_BRK: begin
          if ((din != PS2_EXT) && (din != PS2_BRK)) begin
            hit_brk = 1'b1;
            ev_code = {1'b1, din};
          end
        end
        default: ;
      endcase
    end
  end

  // Pause sequence byte counter, loaded on the E1 prefix
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      pause_cnt <= '0;
    else if ((state == IDLE) && dnew && (din == PS2_PAUSE))
      pause_cnt <= PW'(PAUSE_SKIP);
    else if ((state == PAUSE) && dnew && (pause_cnt != '0))
      pause_cnt <= pause_cnt - 1'b1;
  end

`ifdef KBD_REPEAT_FILTER_EN
  keycode last_make;
  logic   last_valid;

  assign suppress = hit_make && last_valid && (ev_code == last_make);

  // remember the last pressed key until its release
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      last_make  <= '0;
      last_valid <= 1'b0;
    end else if (emit_make) begin
      last_make  <= ev_code;
      last_valid <= 1'b1;
    end else if (hit_brk && (ev_code == last_make)) begin
      last_valid <= 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign emit_make = hit_make && !suppress;

  // registered outputs; keyCode holds until the next emitted event
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      key_code_q <= '0;
      make_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      make_q <= emit_make;
      brk_q  <= hit_brk;
      if (emit_make || hit_brk) key_code_q <= ev_code;
    end
  end

  assign bus.keyCode = key_code_q;
  assign bus.make    = make_q;
  assign bus.brakee  = brk_q;

endmodule

// File: tb/tb_kbd_scan_decoder.sv
// Directed bench for kbd_scan_decoder (small timeout for fast expiry tests).
module tb_kbd_scan_decoder;
  import kbd_scan_decoder_pkg::*;

  localparam int T = 16;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic seen;

  kbd_scan_decoder_if bus ();

  kbd_scan_decoder #(.TIMEOUT_CYCLES(T), .PAUSE_SKIP(7)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // make, brakee and keyCode together
  task automatic ev(input string tag, input logic m, input logic b, input logic [8:0] code);
    chk({tag, ".make"}, {8'h0, bus.make}, {8'h0, m});
    chk({tag, ".brakee"}, {8'h0, bus.brakee}, {8'h0, b});
    chk({tag, ".code"}, bus.keyCode, code);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one-cycle strobe; returns #1 after the sampling edge
  task automatic send(input logic [7:0] b);
    bus.din    = b;
    bus.dinNew = 1'b1;
    @(posedge clk);
    #1;
    bus.dinNew = 1'b0;
  endtask

  initial begin
    bus.din    = 8'h00;
    bus.dinNew = 1'b0;
    #2;
    ev("reset", 1'b0, 1'b0, 9'h000);
    tick(2);
    resetN = 1'b1;
    tick(1);

    // plain make then break
    send(8'h29);  ev("mk29", 1'b1, 1'b0, 9'h029);
    tick(1);      ev("mk29_1cyc", 1'b0, 1'b0, 9'h029);
    send(8'hF0);  ev("f0_quiet", 1'b0, 1'b0, 9'h029);
    send(8'h29);  ev("br29", 1'b0, 1'b1, 9'h029);
    tick(1);      ev("br29_1cyc", 1'b0, 1'b0, 9'h029);

    // extended make and break
    send(8'hE0);  ev("e0_quiet", 1'b0, 1'b0, 9'h029);
    send(8'h75);  ev("mk175", 1'b1, 1'b0, 9'h175);
    send(8'hE0);
    send(8'hF0);  ev("e0f0_quiet", 1'b0, 1'b0, 9'h175);
    send(8'h75);  ev("br175", 1'b0, 1'b1, 9'h175);

    // Pause sequence produces nothing, then decoding resumes
    seen = 1'b0;
    send(8'hE1);  seen |= bus.make | bus.brakee;
    send(8'h14);  seen |= bus.make | bus.brakee;
    send(8'h77);  seen |= bus.make | bus.brakee;
    send(8'hE1);  seen |= bus.make | bus.brakee;
    send(8'hF0);  seen |= bus.make | bus.brakee;
    send(8'h14);  seen |= bus.make | bus.brakee;
    send(8'hF0);  seen |= bus.make | bus.brakee;
    send(8'h77);  seen |= bus.make | bus.brakee;
    chk("pause_quiet", {8'h0, seen}, 9'h000);
    send(8'h1C);  ev("mk01c", 1'b1, 1'b0, 9'h01C);

    // F0 abandoned after timeout: next byte is a make
    send(8'hF0);
    tick(T);
    send(8'h29);  ev("tmo_mk29", 1'b1, 1'b0, 9'h029);
    // byte on the exact expiry cycle still completes the break
    send(8'hF0);
    tick(T - 1);
    send(8'h29);  ev("edge_br29", 1'b0, 1'b1, 9'h029);

    // housekeeping bytes are ignored
    send(8'hAA);  ev("aa", 1'b0, 1'b0, 9'h029);
    send(8'hFA);  ev("fa", 1'b0, 1'b0, 9'h029);
    send(8'hEE);  ev("ee", 1'b0, 1'b0, 9'h029);

    // reset mid-sequence discards the E0 prefix
    send(8'h75);  ev("mk075a", 1'b1, 1'b0, 9'h075);
    send(8'hE0);
    #2 resetN = 1'b0;
    #2;           ev("midrst", 1'b0, 1'b0, 9'h000);
    @(negedge clk);
    resetN = 1'b1;
    tick(1);
    send(8'h75);  ev("mk075", 1'b1, 1'b0, 9'h075);

    // typematic repeat
    send(8'h1D);  ev("rep1", 1'b1, 1'b0, 9'h01D);
`ifdef KBD_REPEAT_FILTER_EN
    send(8'h1D);  ev("rep2", 1'b0, 1'b0, 9'h01D);
    send(8'h1D);  ev("rep3", 1'b0, 1'b0, 9'h01D);
`else
    send(8'h1D);  ev("rep2", 1'b1, 1'b0, 9'h01D);
    send(8'h1D);  ev("rep3", 1'b1, 1'b0, 9'h01D);
`endif
    send(8'hF0);  ev("rep4", 1'b0, 1'b0, 9'h01D);
    send(8'h1D);  ev("rep5", 1'b0, 1'b1, 9'h01D);
    send(8'h1D);  ev("rep6", 1'b1, 1'b0, 9'h01D);
`ifdef KBD_REPEAT_FILTER_EN
    send(8'h1D);  ev("rep7", 1'b0, 1'b0, 9'h01D);
`else
    send(8'h1D);  ev("rep7", 1'b1, 1'b0, 9'h01D);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
